// File: rtl/handshake_fifo.sv
// Elastic FIFO stage between a dataflow graph's output operator and the consumer.
// Pulls words upstream with req_l/ack_l, serves them downstream with req_r/ack_r, and counts traffic.
module handshake_fifo #(
  parameter int data_width = 32,
  parameter int depth      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    req_l,
  input  logic                    ack_l,
  input  logic [data_width-1:0]   din,
  input  logic                    req_r,
  output logic                    ack_r,
  output logic [data_width-1:0]   dout,
  output logic [$clog2(depth):0]  level,
  output logic [31:0]             count_in,
  output logic [31:0]             count_out,
  output logic                    overflow
);

  localparam int ptr_w = $clog2(depth);
  localparam int lvl_w = ptr_w + 1;
  localparam logic [lvl_w-1:0] full_lvl = lvl_w'(depth);

  // Handshake: each side uses a level request answered by a single-cycle ack that
  // carries the data in the same cycle. Upstream, req_l drops for one cycle after
  // every ack_l, so one request never yields two acks. Downstream, ack_r is never
  // high two cycles in a row, so a consumer sees at most one word per request.

  logic [data_width-1:0] mem_q [depth];

  logic [ptr_w-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0]      rd_ptr_q, rd_ptr_d;
  logic [lvl_w-1:0]      level_q, level_d;
  logic [31:0]           count_in_q, count_in_d;
  logic [31:0]           count_out_q, count_out_d;
  logic                  overflow_q, overflow_d;
  logic                  req_l_q, req_l_d;
  logic                  ack_r_q, ack_r_d;
  logic [data_width-1:0] dout_q, dout_d;

  logic push;
  logic drop;
  logic pop;

  always_comb begin
    push        = ack_l && (level_q < full_lvl);
    drop        = ack_l && (level_q == full_lvl);
    // Pop uses the registered level, so a word just written is not visible yet.
    pop         = req_r && !ack_r_q && (level_q != '0);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_in_d  = count_in_q;
    count_out_d = count_out_q;
    dout_d      = dout_q;

    if (push) begin
      wr_ptr_d   = wr_ptr_q + ptr_w'(1);
      count_in_d = count_in_q + 32'd1;
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + ptr_w'(1);
      count_out_d = count_out_q + 32'd1;
      dout_d      = mem_q[rd_ptr_q];
    end

    level_d    = level_q + lvl_w'(push) - lvl_w'(pop);
    overflow_d = overflow_q | drop;
    req_l_d    = !ack_l && (level_d < full_lvl);
    ack_r_d    = pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      count_in_q  <= '0;
      count_out_q <= '0;
      overflow_q  <= 1'b0;
      req_l_q     <= 1'b0;
      ack_r_q     <= 1'b0;
      dout_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      count_in_q  <= count_in_d;
      count_out_q <= count_out_d;
      overflow_q  <= overflow_d;
      req_l_q     <= req_l_d;
      ack_r_q     <= ack_r_d;
      dout_q      <= dout_d;
    end
  end

  // Storage carries no reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign req_l     = req_l_q;
  assign ack_r     = ack_r_q;
  assign dout      = dout_q;
  assign level     = level_q;
  assign count_in  = count_in_q;
  assign count_out = count_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_handshake_fifo.sv
// Scoreboard bench for handshake_fifo: drivers push into a queue model, a monitor
// one step after every rising edge pops on ack_r and checks data, level, counters and flags.
module tb_handshake_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_l;
  logic          ack_l = 1'b0;
  logic [DW-1:0] din   = '0;
  logic          req_r = 1'b0;
  logic          ack_r;
  logic [DW-1:0] dout;
  logic [$clog2(DEPTH):0] level;
  logic [31:0]   count_in;
  logic [31:0]   count_out;
  logic          overflow;

  handshake_fifo #(.data_width(DW), .depth(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_l(req_l), .ack_l(ack_l), .din(din),
    .req_r(req_r), .ack_r(ack_r), .dout(dout),
    .level(level), .count_in(count_in), .count_out(count_out),
    .overflow(overflow)
  );

  // reference model: queue of words held, plus traffic counters and sticky error
  logic [DW-1:0] exp_q[$];
  int unsigned   n_in  = 0;
  int unsigned   n_out = 0;
  logic          ovf_m = 1'b0;
  logic          prev_ack_r = 1'b0;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic [DW-1:0] e;
    logic          exp_req;
    #1;
    if (rst) begin
      exp_q.delete();
      n_in = 0;
      n_out = 0;
      ovf_m = 1'b0;
      prev_ack_r = 1'b0;
      check("rst_level", 32'(level), 32'd0);
      check("rst_count_in", count_in, 32'd0);
      check("rst_count_out", count_out, 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_req_l", 32'(req_l), 32'd0);
      check("rst_ack_r", 32'(ack_r), 32'd0);
      check("rst_dout", dout, 32'd0);
    end else begin
      if (ack_r) begin
        check("ack_r_gap", 32'(prev_ack_r), 32'd0);
        check("ack_r_without_req", 32'(req_r), 32'd1);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL ack_r_when_empty: got ack_r=1 dout=%0d expected no ack at %0t", dout, $time);
        end else begin
          e = exp_q.pop_front();
          n_out++;
          check("dout", dout, e);
        end
      end
      prev_ack_r = ack_r;
      exp_req = !ack_l && (exp_q.size() < DEPTH);
      check("level", 32'(level), 32'(exp_q.size()));
      check("count_in", count_in, n_in);
      check("count_out", count_out, n_out);
      check("overflow", 32'(overflow), 32'(ovf_m));
      check("req_l", 32'(req_l), 32'(exp_req));
    end
  end

  // driver tasks; all called at a falling edge and return at a falling edge
  task automatic do_ack(input logic [DW-1:0] d);
    ack_l = 1'b1;
    din   = d;
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(d);
      n_in++;
    end else begin
      ovf_m = 1'b1;
    end
    @(negedge clk);
    ack_l = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    int t = 0;
    while (!req_l && t < 200) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (!req_l) begin
      fails++;
      $display("FAIL push_timeout: got req_l=0 expected req_l=1 for word %0d", d);
    end else begin
      do_ack(d);
    end
  endtask

  task automatic drain();
    int t = 0;
    req_r = 1'b1;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  logic done;

  initial begin
    // reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // fill with consumer idle
    req_r = 1'b0;
    for (int i = 0; i < 4; i++) push_word(DW'(i));
    repeat (4) @(negedge clk);
    check("fill_level", 32'(level), 32'd4);
    check("fill_req_l", 32'(req_l), 32'd0);
    check("fill_count_in", count_in, 32'd4);

    // drain from full
    drain();
    check("drain_count_out", count_out, 32'd4);

    // streaming with both sides always requesting
    req_r = 1'b1;
    for (int i = 0; i < 10; i++) push_word(DW'(100 + i));
    drain();
    check("stream_count_in", count_in, 32'd14);
    check("stream_overflow", 32'(overflow), 32'd0);

    // empty / minimum latency
    req_r = 1'b1;
    begin
      int t = 0;
      while (!req_l && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("lat_req_l", 32'(req_l), 32'd1);
      do_ack_lat();
    end
    repeat (4) @(negedge clk);

    // randomized traffic with a stalling consumer
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          push_word($urandom);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          req_r = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
      end
    join
    drain();

    // overflow by protocol violation
    req_r = 1'b0;
    for (int i = 0; i < 4; i++) push_word(DW'(10 + i));
    repeat (2) @(negedge clk);
    do_ack(DW'(55));
    @(negedge clk);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_level", 32'(level), 32'd4);
    drain();

    // reset mid-operation
    req_r = 1'b0;
    for (int i = 0; i < 3; i++) push_word(DW'(300 + i));
    repeat (2) @(negedge clk);
    check("pre_rst_level", 32'(level), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_l", 32'(req_l), 32'd1);
    push_word(DW'(200));
    push_word(DW'(201));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // single ack with din=7 against an empty FIFO; ack_r due exactly one edge later
  task automatic do_ack_lat();
    ack_l = 1'b1;
    din   = DW'(7);
    exp_q.push_back(DW'(7));
    n_in++;
    @(posedge clk);
    #1;
    check("lat_no_early_ack", 32'(ack_r), 32'd0);
    @(negedge clk);
    ack_l = 1'b0;
    @(posedge clk);
    #1;
    check("lat_ack_r", 32'(ack_r), 32'd1);
    check("lat_dout", dout, 32'd7);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
